// File: rtl/sparse_chunk_sram_writer.sv
`default_nettype none
// ============================================================================
// Module   : sparse_chunk_sram_writer
// Brief    : Write-side controller between the sparse IFM/filter bus
//            generator and one chunk SRAM. Maps {chunk, beat} to an SRAM
//            address, checks beat sequencing, counts nonzeros per chunk and
//            emits a one-cycle chunk-done record for the compute side.
// Options  : SCW_NZ_TRIM_EN - zero data lanes at index >= popcount(map)
// Revision : 1.0 - initial release
// ============================================================================
module sparse_chunk_sram_writer #(
    parameter int BUS_W     = 32,
    parameter int DAT_W     = 8,
    parameter int CYC_NUM   = 9,
    parameter int CHUNK_NUM = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 wr_valid_i,
    input  logic [BUS_W-1:0]                     wr_sparsemap_i,
    input  logic [BUS_W*DAT_W-1:0]               wr_nonzero_data_i,
    input  logic [$clog2(CYC_NUM)-1:0]           wr_dat_count_i,
    input  logic [$clog2(CHUNK_NUM)-1:0]         wr_chunk_count_i,
    output logic                                 sram_wr_en_o,
    output logic [$clog2(CHUNK_NUM*CYC_NUM)-1:0] sram_wr_addr_o,
    output logic [BUS_W-1:0]                     sram_wr_map_o,
    output logic [BUS_W*DAT_W-1:0]               sram_wr_data_o,
    output logic                                 chunk_done_o,
    output logic [$clog2(CHUNK_NUM)-1:0]         chunk_id_o,
    output logic [$clog2(CYC_NUM):0]             chunk_beats_o,
    output logic [$clog2(BUS_W*CYC_NUM+1)-1:0]   chunk_nz_cnt_o,
    output logic                                 seq_err_o
);

    localparam int c_CW = $clog2(CYC_NUM);
    localparam int c_KW = $clog2(CHUNK_NUM);
    localparam int c_AW = $clog2(CHUNK_NUM * CYC_NUM);
    localparam int c_NW = $clog2(BUS_W * CYC_NUM + 1);
    localparam int c_PW = $clog2(BUS_W + 1);

    localparam logic [c_CW:0]   c_CYC_B = (c_CW + 1)'(CYC_NUM);
    localparam logic [c_AW-1:0] c_CYC_A = c_AW'(CYC_NUM);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_KW-1:0]     r_open_id;
    logic [c_CW-1:0]     r_prev_dat;
    logic [c_CW:0]       r_beats;
    logic [c_NW-1:0]     r_nz;

    logic                w_dat_ok;
    logic                w_chunk_ok;
    logic                w_is_start;
    logic                w_is_next;
    logic                w_legal;
    logic                w_switch;
    logic [c_PW-1:0]     w_pop;
    logic [c_CW:0]       w_new_beats;
    logic [c_NW-1:0]     w_new_nz;
    logic [c_AW-1:0]     w_addr;
    logic [BUS_W*DAT_W-1:0] w_data;

    // Range checks collapse to constant-true when the index port cannot
    // encode an out-of-range value.
    generate
        if ((1 << c_CW) == CYC_NUM) begin : g_dat_full
            assign w_dat_ok = 1'b1;
        end else begin : g_dat_lim
            assign w_dat_ok = ({1'b0, wr_dat_count_i} < c_CYC_B);
        end
        if ((1 << c_KW) == CHUNK_NUM) begin : g_chunk_full
            assign w_chunk_ok = 1'b1;
        end else begin : g_chunk_lim
            localparam logic [c_KW:0] c_CHK_B = (c_KW + 1)'(CHUNK_NUM);
            assign w_chunk_ok = ({1'b0, wr_chunk_count_i} < c_CHK_B);
        end
    endgenerate

    // Popcount of the incoming sparsemap: nonzero lanes carried by this beat.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < BUS_W; i++) begin
            w_pop = w_pop + c_PW'(wr_sparsemap_i[i]);
        end
    end

`ifdef SCW_NZ_TRIM_EN
    // Lanes past the nonzero count carry no payload; force them to zero.
    generate
        for (genvar i = 0; i < BUS_W; i++) begin : g_trim
            localparam logic [c_PW-1:0] c_IDX = c_PW'(i);
            assign w_data[i*DAT_W +: DAT_W] = (c_IDX < w_pop) ?
                                              wr_nonzero_data_i[i*DAT_W +: DAT_W] : '0;
        end
    endgenerate
`else
    assign w_data = wr_nonzero_data_i;
`endif

    // dat_count==0 always opens a chunk; otherwise the beat must continue
    // the open chunk with the next index.
    assign w_is_start  = (wr_dat_count_i == '0);
    assign w_is_next   = (r_state == S_FILL) &&
                         (wr_chunk_count_i == r_open_id) &&
                         (wr_dat_count_i == r_prev_dat + c_CW'(1));
    assign w_legal     = w_dat_ok && w_chunk_ok && (w_is_start || w_is_next);
    assign w_switch    = (r_state == S_FILL) && w_is_start;
    assign w_new_beats = w_is_start ? (c_CW + 1)'(1) : r_beats + (c_CW + 1)'(1);
    assign w_new_nz    = (w_is_start ? '0 : r_nz) + c_NW'(w_pop);
    assign w_addr      = c_AW'(wr_chunk_count_i) * c_CYC_A + c_AW'(wr_dat_count_i);

    // Chunk FSM, SRAM write port and chunk-done record, all registered.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state        <= S_IDLE;
            r_open_id      <= '0;
            r_prev_dat     <= '0;
            r_beats        <= '0;
            r_nz           <= '0;
            sram_wr_en_o   <= 1'b0;
            sram_wr_addr_o <= '0;
            sram_wr_map_o  <= '0;
            sram_wr_data_o <= '0;
            chunk_done_o   <= 1'b0;
            chunk_id_o     <= '0;
            chunk_beats_o  <= '0;
            chunk_nz_cnt_o <= '0;
            seq_err_o      <= 1'b0;
        end else begin
            sram_wr_en_o <= 1'b0;
            chunk_done_o <= 1'b0;
            if (wr_valid_i) begin
                if (!w_legal) begin
                    seq_err_o <= 1'b1;
                end else begin
                    sram_wr_en_o   <= 1'b1;
                    sram_wr_addr_o <= w_addr;
                    sram_wr_map_o  <= wr_sparsemap_i;
                    sram_wr_data_o <= w_data;
                    // A new chunk started while one was open: report the old one.
                    if (w_switch) begin
                        chunk_done_o   <= 1'b1;
                        chunk_id_o     <= r_open_id;
                        chunk_beats_o  <= r_beats;
                        chunk_nz_cnt_o <= r_nz;
                    end
                    if (w_new_beats == c_CYC_B) begin
                        chunk_done_o   <= 1'b1;
                        chunk_id_o     <= wr_chunk_count_i;
                        chunk_beats_o  <= w_new_beats;
                        chunk_nz_cnt_o <= w_new_nz;
                        r_state        <= S_IDLE;
                        r_beats        <= '0;
                        r_nz           <= '0;
                    end else begin
                        r_state        <= S_FILL;
                        r_open_id      <= wr_chunk_count_i;
                        r_prev_dat     <= wr_dat_count_i;
                        r_beats        <= w_new_beats;
                        r_nz           <= w_new_nz;
                    end
                end
            end else if (r_state == S_FILL) begin
                // Stream gap closes the open chunk.
                chunk_done_o   <= 1'b1;
                chunk_id_o     <= r_open_id;
                chunk_beats_o  <= r_beats;
                chunk_nz_cnt_o <= r_nz;
                r_state        <= S_IDLE;
                r_beats        <= '0;
                r_nz           <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_chunk_sram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparse_chunk_sram_writer
// Brief    : Directed self-checking bench for sparse_chunk_sram_writer.
//            A chunk-level model predicts every output each cycle; literal
//            expectations pin the model on the key scenarios.
// Options  : SCW_NZ_TRIM_EN - expected write data follows lane trimming
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparse_chunk_sram_writer;

    localparam int BUS_W     = 32;
    localparam int DAT_W     = 8;
    localparam int CYC_NUM   = 9;
    localparam int CHUNK_NUM = 16;
`ifdef SCW_NZ_TRIM_EN
    localparam bit c_TRIM = 1'b1;
`else
    localparam bit c_TRIM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid = 1'b0;
    logic [31:0]  map = '0;
    logic [255:0] data = '0;
    logic [3:0]   dat = '0;
    logic [3:0]   chunk = '0;

    logic         sram_wr_en_o;
    logic [7:0]   sram_wr_addr_o;
    logic [31:0]  sram_wr_map_o;
    logic [255:0] sram_wr_data_o;
    logic         chunk_done_o;
    logic [3:0]   chunk_id_o;
    logic [4:0]   chunk_beats_o;
    logic [8:0]   chunk_nz_cnt_o;
    logic         seq_err_o;

    sparse_chunk_sram_writer #(
        .BUS_W(BUS_W), .DAT_W(DAT_W), .CYC_NUM(CYC_NUM), .CHUNK_NUM(CHUNK_NUM)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .wr_valid_i(valid),
        .wr_sparsemap_i(map),
        .wr_nonzero_data_i(data),
        .wr_dat_count_i(dat),
        .wr_chunk_count_i(chunk),
        .sram_wr_en_o(sram_wr_en_o),
        .sram_wr_addr_o(sram_wr_addr_o),
        .sram_wr_map_o(sram_wr_map_o),
        .sram_wr_data_o(sram_wr_data_o),
        .chunk_done_o(chunk_done_o),
        .chunk_id_o(chunk_id_o),
        .chunk_beats_o(chunk_beats_o),
        .chunk_nz_cnt_o(chunk_nz_cnt_o),
        .seq_err_o(seq_err_o)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- chunk-level model ----------------
    bit           m_open = 1'b0;
    int           m_id = 0, m_beats = 0, m_nz = 0;
    logic         e_en, e_done, e_err;
    logic [7:0]   e_addr;
    logic [31:0]  e_map;
    logic [255:0] e_data;
    logic [3:0]   e_id;
    logic [4:0]   e_beats;
    logic [8:0]   e_nz;
    bit           have_exp = 1'b0;

    logic [7:0]   log_addr[$];
    logic [255:0] log_data[$];

    function automatic logic [255:0] model_data(input logic [31:0] m, input logic [255:0] d);
        logic [255:0] r;
        int n;
        r = d;
        n = $countones(m);
        for (int i = 0; i < BUS_W; i++)
            if (c_TRIM && i >= n) r[i*DAT_W +: DAT_W] = 8'h00;
        return r;
    endfunction

    task automatic emit(input int id, input int b, input int n);
        e_done  = 1'b1;
        e_id    = 4'(id);
        e_beats = 5'(b);
        e_nz    = 9'(n);
    endtask

    // Predict the outputs after the next rising edge from the inputs now applied.
    task automatic model_step();
        bit ok;
        e_en   = 1'b0;
        e_done = 1'b0;
        if (!rst) begin
            m_open = 1'b0; m_id = 0; m_beats = 0; m_nz = 0;
            e_addr = '0; e_map = '0; e_data = '0;
            e_id = '0; e_beats = '0; e_nz = '0; e_err = 1'b0;
        end else if (valid) begin
            ok = (int'(dat) < CYC_NUM) && (int'(chunk) < CHUNK_NUM) &&
                 ((int'(dat) == 0) ||
                  (m_open && int'(chunk) == m_id && int'(dat) == m_beats));
            if (!ok) begin
                e_err = 1'b1;
            end else begin
                e_en   = 1'b1;
                e_addr = 8'(int'(chunk) * CYC_NUM + int'(dat));
                e_map  = map;
                e_data = model_data(map, data);
                if (int'(dat) == 0) begin
                    if (m_open) emit(m_id, m_beats, m_nz);
                    m_beats = 0;
                    m_nz    = 0;
                end
                m_open  = 1'b1;
                m_id    = int'(chunk);
                m_beats = m_beats + 1;
                m_nz    = m_nz + $countones(map);
                if (m_beats == CYC_NUM) begin
                    emit(m_id, m_beats, m_nz);
                    m_open = 1'b0;
                end
            end
        end else if (m_open) begin
            emit(m_id, m_beats, m_nz);
            m_open = 1'b0;
        end
    endtask

    // Compare process: every falling edge check outputs, log writes, advance model.
    initial begin
        forever begin
            @(negedge clk);
            if (have_exp) begin
                check("wr_en", 256'(sram_wr_en_o), 256'(e_en));
                if (e_en) begin
                    check("wr_addr", 256'(sram_wr_addr_o), 256'(e_addr));
                    check("wr_map", 256'(sram_wr_map_o), 256'(e_map));
                    check("wr_data", sram_wr_data_o, e_data);
                end
                check("done", 256'(chunk_done_o), 256'(e_done));
                check("chunk_id", 256'(chunk_id_o), 256'(e_id));
                check("chunk_beats", 256'(chunk_beats_o), 256'(e_beats));
                check("chunk_nz", 256'(chunk_nz_cnt_o), 256'(e_nz));
                check("seq_err", 256'(seq_err_o), 256'(e_err));
            end
            if (sram_wr_en_o === 1'b1) begin
                log_addr.push_back(sram_wr_addr_o);
                log_data.push_back(sram_wr_data_o);
            end
            model_step();
            have_exp = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [31:0] m, input int d, input int c,
                         input logic [7:0] b);
        @(posedge clk);
        #1;
        valid = v;
        map   = m;
        dat   = 4'(d);
        chunk = 4'(c);
        data  = {32{b}};
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 0, 0, 8'h00);
    endtask

    task automatic wait_done(input string tag, input int id, input int beats, input int nz);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (chunk_done_o === 1'b1) begin
                seen = 1'b1;
                check({tag, " id"}, 256'(chunk_id_o), 256'(id));
                check({tag, " beats"}, 256'(chunk_beats_o), 256'(beats));
                check({tag, " nz"}, 256'(chunk_nz_cnt_o), 256'(nz));
            end
        end
        if (!seen) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s done: got no pulse expected pulse within 12 cycles", tag);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [255:0] trim_exp;

        // T1: reset held for three cycles of a valid stream.
        drive(1'b1, 32'hFFFF_FFFF, 0, 0, 8'h11);
        drive(1'b1, 32'hFFFF_FFFF, 1, 0, 8'h22);
        drive(1'b1, 32'hFFFF_FFFF, 2, 0, 8'h33);
        @(negedge clk);
        check("T1 wr_en", 256'(sram_wr_en_o), 256'(0));
        check("T1 done", 256'(chunk_done_o), 256'(0));
        check("T1 addr", 256'(sram_wr_addr_o), 256'(0));
        check("T1 seq_err", 256'(seq_err_o), 256'(0));
        @(posedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        idle(2);

        // T2: chunk 2, three beats, then a gap.
        log_addr.delete();
        log_data.delete();
        drive(1'b1, 32'h0000_00FF, 0, 2, 8'h01);
        drive(1'b1, 32'h0000_00FF, 1, 2, 8'h02);
        drive(1'b1, 32'h0000_00FF, 2, 2, 8'h03);
        idle(1);
        wait_done("T2", 2, 3, 24);
        idle(1);
        check("T2 writes", 256'(log_addr.size()), 256'(3));
        if (log_addr.size() == 3) begin
            check("T2 addr0", 256'(log_addr[0]), 256'(18));
            check("T2 addr1", 256'(log_addr[1]), 256'(19));
            check("T2 addr2", 256'(log_addr[2]), 256'(20));
        end

        // T3: full chunk 0, then chunk 1 beat 0 back-to-back.
        log_addr.delete();
        log_data.delete();
        for (int i = 0; i < CYC_NUM; i++) drive(1'b1, 32'hFFFF_FFFF, i, 0, 8'(i + 1));
        drive(1'b1, 32'hFFFF_FFFF, 0, 1, 8'h5A);
        wait_done("T3", 0, 9, 288);
        idle(3);
        check("T3 writes", 256'(log_addr.size()), 256'(10));
        if (log_addr.size() == 10) begin
            check("T3 addr8", 256'(log_addr[8]), 256'(8));
            check("T3 addr9", 256'(log_addr[9]), 256'(9));
        end
        check("T3 seq_err", 256'(seq_err_o), 256'(0));

        // T4: chunk 1 interrupted by chunk 3 at dat 0.
        log_addr.delete();
        log_data.delete();
        drive(1'b1, 32'h0000_0F0F, 0, 1, 8'h10);
        drive(1'b1, 32'h0000_0F0F, 1, 1, 8'h20);
        drive(1'b1, 32'h0000_0F0F, 0, 3, 8'h30);
        idle(1);
        wait_done("T4", 1, 2, 16);
        idle(2);
        check("T4 writes", 256'(log_addr.size()), 256'(3));
        if (log_addr.size() == 3) check("T4 addr2", 256'(log_addr[2]), 256'(27));
        check("T4 seq_err", 256'(seq_err_o), 256'(0));

        // T5: sequencing errors (a 4-bit chunk index cannot exceed 15 here).
        log_addr.delete();
        log_data.delete();
        drive(1'b1, 32'h0000_0001, 0, 5, 8'h01);
        drive(1'b1, 32'h0000_0001, 2, 5, 8'h02);   // skip 0->2
        drive(1'b1, 32'h0000_0001, 1, 5, 8'h03);   // chunk still open
        idle(1);
        wait_done("T5", 5, 2, 2);
        check("T5 seq_err skip", 256'(seq_err_o), 256'(1));
        drive(1'b1, 32'h0000_0001, 1, 6, 8'h04);   // first beat at dat 1
        idle(1);
        drive(1'b1, 32'h0000_0001, 9, 7, 8'h05);   // dat out of range
        idle(3);
        check("T5 writes", 256'(log_addr.size()), 256'(2));
        if (log_addr.size() == 2) begin
            check("T5 addr0", 256'(log_addr[0]), 256'(45));
            check("T5 addr1", 256'(log_addr[1]), 256'(46));
        end
        check("T5 seq_err sticky", 256'(seq_err_o), 256'(1));

        // T6: lane trimming on a two-lane map.
        log_addr.delete();
        log_data.delete();
        drive(1'b1, 32'h0000_0003, 0, 4, 8'hAB);
        idle(3);
        trim_exp = c_TRIM ? {240'h0, 16'hABAB} : {32{8'hAB}};
        check("T6 writes", 256'(log_addr.size()), 256'(1));
        if (log_data.size() == 1) begin
            check("T6 addr", 256'(log_addr[0]), 256'(36));
            check("T6 data", log_data[0], trim_exp);
        end

        // Reset again: sticky error must clear.
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        #1;
        rst = 1'b1;
        idle(2);
        check("reset clears seq_err", 256'(seq_err_o), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
